mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master Wishbone pipelined arbiter that shares the single instruction/data memory port between the instruction fetch stage (master 0) and the load/store stage (master 1). It sits between the pipeline stages and the external memory bus. A master owns the bus for its whole Wishbone cycle (cyc high). Ties are broken round-robin or by fixed data priority. Non-owners see stall asserted until they are granted.

## Interface
Parameters:
- PRIORITY_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to master 1 (load/store).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- m0_adr_i  in  32  fetch address
- m0_dat_o  out  32  read data to fetch stage
- m0_we_i  in  1  fetch write enable
- m0_sel_i  in  4  fetch byte select
- m0_stb_i  in  1  fetch strobe
- m0_ack_o  out  1  fetch acknowledge
- m0_cyc_i  in  1  fetch cycle
- m0_stall_o  out  1  fetch stall
- m1_adr_i  in  32  load/store address
- m1_dat_i  in  32  store write data
- m1_dat_o  out  32  load read data
- m1_we_i  in  1  load/store write enable
- m1_sel_i  in  4  load/store byte select
- m1_stb_i  in  1  load/store strobe
- m1_ack_o  out  1  load/store acknowledge
- m1_cyc_i  in  1  load/store cycle
- m1_stall_o  out  1  load/store stall
- wb_adr_o  out  32  memory address
- wb_dat_o  out  32  memory write data
- wb_dat_i  in  32  memory read data
- wb_we_o  out  1  memory write enable
- wb_sel_o  out  4  memory byte select
- wb_stb_o  out  1  memory strobe
- wb_ack_i  in  1  memory acknowledge
- wb_cyc_o  out  1  memory cycle
- wb_stall_i  in  1  memory stall
- grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 0 when idle

## Operation
- Registers: state_q ∈ {IDLE, GRANT_0, GRANT_1}; last_q (1 bit, index of the last granted master).
- Reset (async): state_q = IDLE, last_q = 1. The first round-robin tie after reset goes to m0, the boot fetch.
- IDLE:
  - No request: stay in IDLE.
  - Only mX_cyc_i high: go to GRANT_X.
  - Both high, PRIORITY_MODE = 0: grant the master ≠ last_q.
  - Both high, PRIORITY_MODE = 1: grant m1.
  - On every entry into GRANT_X, last_q ← X.
- GRANT_X, mX_cyc_i still high: stay in GRANT_X.
- GRANT_X, mX_cyc_i low:
  - If the other master's cyc is high, hand over directly to GRANT_other. Fixed and round-robin modes behave the same here.
  - Otherwise go to IDLE.
- Ownership is never preempted mid-cycle.
- Slave-side mux (combinational from state_q):
  - GRANT_X: wb_adr/we/sel/stb/cyc_o = mX_*_i.
  - wb_dat_o = m1_dat_i in GRANT_1, otherwise 0.
  - IDLE: all wb_*_o = 0.
- Master-side responses:
  - mX_dat_o = wb_dat_i always (qualified by ack).
  - mX_ack_o = wb_ack_i only in GRANT_X, otherwise 0.
  - mX_stall_o = wb_stall_i in GRANT_X, otherwise 1.
- Acks arriving in IDLE are dropped.
- grant_o = {state_q == GRANT_1, state_q == GRANT_0}.

## Timing
- Arbitration latency is 1 cycle:
  - Cycle N: mX_cyc_i rises in IDLE; mX_stall_o = 1.
  - Cycle N+1: state = GRANT_X; the held stb is forwarded, and is accepted if wb_stall_i = 0.
- Request acceptance: wb_stb_o && !wb_stall_i in the owner's state. A master keeps stb and address stable while its stall_o = 1.
- Release/handover:
  - Cycle K: owner drops cyc; wb_cyc_o = 0 in cycle K, because the mux is combinational.
  - Cycle K+1: the waiting master is granted. There is no dead cycle beyond the one arbitration cycle.
- Back-to-back cycles by the same master:
  - Each drop of cyc for ≥1 cycle is a re-arbitration point.
  - If the same master raises cyc again while in IDLE, it regains the bus after 1 cycle.
- Simultaneous events:
  - Owner drops cyc while the other raises cyc in the same cycle: handover at the next edge.
  - Both rise together: the policy above applies.
- Reset mid-cycle:
  - Immediate IDLE.
  - wb_cyc_o/wb_stb_o = 0 asynchronously.
  - Both stall_o = 1, both ack_o = 0.
  - In-flight ack is discarded.
- Reset values:
  - wb_adr_o = 0, wb_dat_o = 0, wb_we_o = 0, wb_sel_o = 0, wb_stb_o = 0, wb_cyc_o = 0.
  - m0_ack_o = 0, m1_ack_o = 0.
  - m0_stall_o = 1, m1_stall_o = 1.
  - grant_o = 0.
  - m*_dat_o = wb_dat_i.

## Test plan
- Single fetch after reset:
  - Stimulus: m0 cyc/stb, adr 0x0000_1000, memory acks 2 cycles later with 0xDEAD_BEEF.
  - Required: grant_o = 01 one cycle after the request; wb_adr_o = 0x1000; m0_ack_o pulses with m0_dat_o = 0xDEAD_BEEF; m1_ack_o stays 0.
- Simultaneous requests, PRIORITY_MODE = 0:
  - Stimulus: m0 and m1 raise cyc together twice in a row.
  - Required: first grant m0 (last_q = 1 after reset), second grant m1.
  - With PRIORITY_MODE = 1, m1 wins both.
- Contention stall:
  - Stimulus: m1 owns the bus with ack delayed 5 cycles; m0 requests meanwhile.
  - Required: m0_stall_o = 1 throughout; m0 is granted the cycle after m1_cyc_i falls; m0 adr appears on wb_adr_o.
- Memory stall passthrough:
  - Stimulus: m1 store to 0x2000 with data 0x1234_5678 and sel 0x3; wb_stall_i high for 3 cycles.
  - Required: m1_stall_o mirrors wb_stall_i; wb_we_o = 1, wb_sel_o = 0x3, wb_dat_o = 0x1234_5678 held stable.
- Async reset mid-cycle:
  - Stimulus: assert rst_i between clock edges while in GRANT_0 awaiting ack.
  - Required: wb_cyc_o/wb_stb_o drop immediately; grant_o = 00; a subsequent wb_ack_i produces no m*_ack_o.
- Stray ack in IDLE:
  - Stimulus: wb_ack_i pulsed with no owner.
  - Required: both ack_o remain 0; state remains IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-master Wishbone pipelined arbiter sharing one memory port
//             between instruction fetch (master 0) and load/store (master 1).
//             A master keeps the bus for its entire Wishbone cycle (cyc high).
//             Simultaneous requests from idle are resolved round-robin or by
//             fixed priority to load/store.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PRIORITY_MODE : 0 = round-robin, 1 = fixed priority to master 1
//  Ports
//    clk_i, rst_i            clock, asynchronous active-high reset
//    m0_*                    fetch master (read-only, no write data input)
//    m1_*                    load/store master
//    wb_*                    shared memory bus (master side of the slave)
//    grant_o[1:0]            one-hot current owner, 0 when idle
// ============================================================================
module mem_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0 : instruction fetch
  input  logic [31:0] m0_adr_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  input  logic        m0_cyc_i,
  output logic        m0_stall_o,
  // master 1 : load/store
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  input  logic        m1_cyc_i,
  output logic        m1_stall_o,
  // shared memory bus
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  // ownership status
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_0 = 2'd1,
    GRANT_1 = 2'd2
  } state_t;

  localparam logic c_FIXED_PRIO = (PRIORITY_MODE != 0);

  state_t state_q, state_d;
  logic   last_q,  last_d;   // index of the most recently granted master

  // --------------------------------------------------------------------------
  // Next-state logic. Ownership only changes when the owner drops cyc, so a
  // cycle is never split between masters.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (c_FIXED_PRIO) begin
            state_d = GRANT_1;
          end else begin
            // Round-robin: favour the master that was not served last.
            state_d = last_q ? GRANT_0 : GRANT_1;
          end
        end else if (m0_cyc_i) begin
          state_d = GRANT_0;
        end else if (m1_cyc_i) begin
          state_d = GRANT_1;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT_0: begin
        if (m0_cyc_i) begin
          state_d = GRANT_0;
        end else if (m1_cyc_i) begin
          // Direct handover avoids an extra idle cycle for a waiting master.
          state_d = GRANT_1;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT_1: begin
        if (m1_cyc_i) begin
          state_d = GRANT_1;
        end else if (m0_cyc_i) begin
          state_d = GRANT_0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Staying in a grant state re-records the same index, so tracking the
    // destination is equivalent to updating only on entry.
    if (state_d == GRANT_0) begin
      last_d = 1'b0;
    end else if (state_d == GRANT_1) begin
      last_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers. last_q resets to 1 so the first tie goes to the fetch
  // master (boot fetch).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Bus multiplexing, combinational from state_q. Because state_q resets
  // asynchronously, wb_cyc_o/wb_stb_o fall the instant reset is asserted,
  // and an owner dropping cyc is visible on wb_cyc_o in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    wb_adr_o   = 32'h0;
    wb_dat_o   = 32'h0;
    wb_we_o    = 1'b0;
    wb_sel_o   = 4'h0;
    wb_stb_o   = 1'b0;
    wb_cyc_o   = 1'b0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;

    unique case (state_q)
      GRANT_0: begin
        wb_adr_o   = m0_adr_i;
        wb_we_o    = m0_we_i;
        wb_sel_o   = m0_sel_i;
        wb_stb_o   = m0_stb_i;
        wb_cyc_o   = m0_cyc_i;
        m0_ack_o   = wb_ack_i;
        m0_stall_o = wb_stall_i;
      end

      GRANT_1: begin
        wb_adr_o   = m1_adr_i;
        wb_dat_o   = m1_dat_i;
        wb_we_o    = m1_we_i;
        wb_sel_o   = m1_sel_i;
        wb_stb_o   = m1_stb_i;
        wb_cyc_o   = m1_cyc_i;
        m1_ack_o   = wb_ack_i;
        m1_stall_o = wb_stall_i;
      end

      default: begin
        // Idle: bus quiet, acks from the slave are discarded.
      end
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;

  assign grant_o  = {state_q == GRANT_1, state_q == GRANT_0};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed, scoreboard-checked bench for mem_arbiter. Two
//             instances share the stimulus: round-robin (dut) and fixed
//             priority (dut_p). Expected acknowledges are queued as
//             transactions are issued and popped by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] m0_adr_i, m1_adr_i, m1_dat_i, wb_dat_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i;
  logic        m1_we_i, m1_stb_i, m1_cyc_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        wb_ack_i, wb_stall_i;

  logic [31:0] m0_dat_o, m1_dat_o, wb_adr_o, wb_dat_o;
  logic        m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic [1:0]  grant_o;

  logic [31:0] p_m0_dat_o, p_m1_dat_o, p_wb_adr_o, p_wb_dat_o;
  logic        p_m0_ack_o, p_m0_stall_o, p_m1_ack_o, p_m1_stall_o;
  logic        p_wb_we_o, p_wb_stb_o, p_wb_cyc_o;
  logic [3:0]  p_wb_sel_o;
  logic [1:0]  p_grant_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        mst;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mem_arbiter #(.PRIORITY_MODE(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
    .m0_cyc_i(m0_cyc_i), .m0_stall_o(m0_stall_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
    .m1_ack_o(m1_ack_o), .m1_cyc_i(m1_cyc_i), .m1_stall_o(m1_stall_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i),
    .grant_o(grant_o)
  );

  mem_arbiter #(.PRIORITY_MODE(1)) dut_p (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_o(p_m0_dat_o), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_ack_o(p_m0_ack_o),
    .m0_cyc_i(m0_cyc_i), .m0_stall_o(p_m0_stall_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(p_m1_dat_o),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
    .m1_ack_o(p_m1_ack_o), .m1_cyc_i(m1_cyc_i), .m1_stall_o(p_m1_stall_o),
    .wb_adr_o(p_wb_adr_o), .wb_dat_o(p_wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(p_wb_we_o), .wb_sel_o(p_wb_sel_o), .wb_stb_o(p_wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_cyc_o(p_wb_cyc_o), .wb_stall_i(wb_stall_i),
    .grant_o(p_grant_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Monitor: every acknowledge the DUT presents must match the oldest
  // expected transaction (owning master and read data).
  always @(negedge clk_i) begin
    if (m0_ack_o || m1_ack_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", {30'b0, m1_ack_o, m0_ack_o}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("ack_master", {30'b0, m1_ack_o, m0_ack_o}, mon_e.mst ? 32'h2 : 32'h1);
        chk("ack_data", mon_e.mst ? m1_dat_o : m0_dat_o, mon_e.dat);
      end
    end
  end

  // Global safety net; no stimulus loop waits on a DUT event.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    m0_adr_i = '0; m0_we_i = 0; m0_sel_i = '0; m0_stb_i = 0; m0_cyc_i = 0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = '0; m1_stb_i = 0; m1_cyc_i = 0;
    wb_dat_i = 32'hA5A5_A5A5; wb_ack_i = 1'b1; wb_stall_i = 1'b0;

    // ---------------- reset values ----------------
    #12;
    chk("rst_wb_cyc",   wb_cyc_o,   0);
    chk("rst_wb_stb",   wb_stb_o,   0);
    chk("rst_wb_adr",   wb_adr_o,   0);
    chk("rst_wb_dat",   wb_dat_o,   0);
    chk("rst_wb_we",    wb_we_o,    0);
    chk("rst_wb_sel",   wb_sel_o,   0);
    chk("rst_m0_ack",   m0_ack_o,   0);
    chk("rst_m1_ack",   m1_ack_o,   0);
    chk("rst_m0_stall", m0_stall_o, 1);
    chk("rst_m1_stall", m1_stall_o, 1);
    chk("rst_grant",    grant_o,    0);
    chk("rst_m0_dat",   m0_dat_o,   32'hA5A5_A5A5);
    chk("rst_m1_dat",   m1_dat_o,   32'hA5A5_A5A5);
    wb_ack_i = 1'b0;
    tick();
    rst_i = 1'b0;

    // ---------------- simultaneous requests ----------------
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200; m1_sel_i = 4'hF;
    #1;
    chk("tie1_arb_grant",   grant_o,   0);
    chk("tie1_arb_grant_p", p_grant_o, 0);
    tick(); #1;
    chk("tie1_grant_rr",  grant_o,    2'b01);
    chk("tie1_grant_fix", p_grant_o,  2'b10);
    chk("tie1_wb_adr",    wb_adr_o,   32'h100);
    chk("tie1_m1_stall",  m1_stall_o, 1);
    chk("tie1_m0_stall",  m0_stall_o, 0);
    chk("tie1_adr_fix",   p_wb_adr_o, 32'h200);
    tick();
    m0_stb_i = 0;
    tick();
    wb_ack_i = 1; wb_dat_i = 32'h1111_1111;
    sb_q.push_back('{mst: 1'b0, dat: 32'h1111_1111});
    tick();
    wb_ack_i = 0; m0_cyc_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    chk("tie1_drop_cyc", wb_cyc_o, 0);
    tick(); #1;
    chk("tie1_idle",   grant_o,   0);
    chk("tie1_idle_p", p_grant_o, 0);
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h104;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h204;
    tick(); #1;
    chk("tie2_grant_rr",  grant_o,    2'b10);
    chk("tie2_grant_fix", p_grant_o,  2'b10);
    chk("tie2_wb_adr",    wb_adr_o,   32'h204);
    chk("tie2_m0_stall",  m0_stall_o, 1);
    tick();
    m1_stb_i = 0;
    tick();
    wb_ack_i = 1; wb_dat_i = 32'h2222_2222;
    sb_q.push_back('{mst: 1'b1, dat: 32'h2222_2222});
    tick();
    wb_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0;
    tick();

    // ---------------- single fetch after reset ----------------
    do_reset();
    m1_dat_i = 32'hCAFE_F00D;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF; m0_we_i = 0;
    #1;
    chk("f_req_grant", grant_o,    0);
    chk("f_req_stall", m0_stall_o, 1);
    tick(); #1;
    chk("f_grant",    grant_o,    2'b01);
    chk("f_wb_adr",   wb_adr_o,   32'h1000);
    chk("f_wb_stb",   wb_stb_o,   1);
    chk("f_wb_cyc",   wb_cyc_o,   1);
    chk("f_wb_dat",   wb_dat_o,   0);
    chk("f_wb_sel",   wb_sel_o,   4'hF);
    chk("f_m0_stall", m0_stall_o, 0);
    tick();
    m0_stb_i = 0;
    tick();
    wb_ack_i = 1; wb_dat_i = 32'hDEAD_BEEF;
    sb_q.push_back('{mst: 1'b0, dat: 32'hDEAD_BEEF});
    #1;
    chk("f_m1_ack", m1_ack_o, 0);
    tick();
    wb_ack_i = 0; m0_cyc_i = 0;
    #1;
    chk("f_rel_cyc", wb_cyc_o, 0);
    tick(); #1;
    chk("f_rel_grant", grant_o, 0);

    // ---------------- contention stall ----------------
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h300; m1_we_i = 0;
    tick(); #1;
    chk("c_m1_grant", grant_o, 2'b10);
    tick();
    m1_stb_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h400;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("c_m0_stall", m0_stall_o, 1);
      chk("c_hold_grant", grant_o, 2'b10);
      tick();
    end
    wb_ack_i = 1; wb_dat_i = 32'h3333_3333;
    sb_q.push_back('{mst: 1'b1, dat: 32'h3333_3333});
    tick();
    wb_ack_i = 0; m1_cyc_i = 0;
    #1;
    chk("c_rel_cyc",   wb_cyc_o,   0);
    chk("c_rel_stall", m0_stall_o, 1);
    tick(); #1;
    chk("c_handover", grant_o,    2'b01);
    chk("c_m0_adr",   wb_adr_o,   32'h400);
    chk("c_m0_go",    m0_stall_o, 0);
    tick();
    m0_stb_i = 0;
    tick();
    wb_ack_i = 1; wb_dat_i = 32'h4444_4444;
    sb_q.push_back('{mst: 1'b0, dat: 32'h4444_4444});
    tick();
    wb_ack_i = 0; m0_cyc_i = 0;
    tick();

    // ---------------- memory stall passthrough ----------------
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h2000; m1_dat_i = 32'h1234_5678;
    m1_sel_i = 4'h3; m1_we_i = 1; wb_stall_i = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s_grant",    grant_o,    2'b10);
      chk("s_m1_stall", m1_stall_o, 1);
      chk("s_wb_we",    wb_we_o,    1);
      chk("s_wb_sel",   wb_sel_o,   4'h3);
      chk("s_wb_dat",   wb_dat_o,   32'h1234_5678);
      chk("s_wb_adr",   wb_adr_o,   32'h2000);
      tick();
    end
    wb_stall_i = 0;
    #1;
    chk("s_m1_unstall", m1_stall_o, 0);
    chk("s_wb_dat_acc", wb_dat_o,   32'h1234_5678);
    tick();
    m1_stb_i = 0;
    tick();
    wb_ack_i = 1; wb_dat_i = 32'h0;
    sb_q.push_back('{mst: 1'b1, dat: 32'h0});
    tick();
    wb_ack_i = 0; m1_cyc_i = 0; m1_we_i = 0;
    tick();

    // ---------------- async reset mid-cycle ----------------
    wb_stall_i = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h500;
    tick();
    tick(); #1;
    chk("r_pre_grant", grant_o,  2'b01);
    chk("r_pre_stb",   wb_stb_o, 1);
    rst_i = 1;
    #1;
    chk("r_cyc",      wb_cyc_o,   0);
    chk("r_stb",      wb_stb_o,   0);
    chk("r_grant",    grant_o,    0);
    chk("r_m0_stall", m0_stall_o, 1);
    chk("r_m1_stall", m1_stall_o, 1);
    tick();
    wb_ack_i = 1; wb_dat_i = 32'h5555_5555;
    #1;
    chk("r_m0_ack", m0_ack_o, 0);
    chk("r_m1_ack", m1_ack_o, 0);
    tick();
    wb_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; rst_i = 0; wb_stall_i = 0;
    tick();

    // ---------------- stray ack in idle ----------------
    wb_ack_i = 1; wb_dat_i = 32'h7777_7777;
    #1;
    chk("i_m0_ack", m0_ack_o, 0);
    chk("i_m1_ack", m1_ack_o, 0);
    chk("i_grant",  grant_o,  0);
    tick();
    wb_ack_i = 0;
    #1;
    chk("i_grant_after", grant_o, 0);
    tick(); tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
